ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory-access stage of the five-stage core. It captures the execute-stage write-back triple (destination address, write enable, result) and HI/LO update each cycle and presents them to the memory stage one cycle later. It honours the global stall vector by holding, inserting a bubble, or passing. It also keeps the temporary state of two-cycle multiply-accumulate instructions and feeds it back to the execute stage.

---
 rtl/ex_mem_pkg.sv | 30 +++
 rtl/ex_mem_pipe_reg.sv | 32 +++
 rtl/ex_mem.sv | 68 ++++++
 tb/tb_ex_mem.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared core widths, NOP encodings and stall-bit indices for the EX/MEM pipeline register.
package ex_mem_pkg;
  localparam int RegBus       = 32;
  localparam int RegAddrBus   = 5;
  localparam int DoubleRegBus = 64;

  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // What a bubble does to a bundle: clear it (forward data) or capture it (feedback state).
  typedef enum logic {CLR_ON_BUBBLE = 1'b0, CAP_ON_BUBBLE = 1'b1} bubble_mode_e;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic                  whilo;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
  } mem_bundle_t;
endpackage

// File: rtl/ex_mem_pipe_reg.sv
// Width-parameterised pipeline register with flush / bubble / pass / hold control.
module pipe_reg
  import ex_mem_pkg::*;
#(
  parameter int           W    = 1,
  parameter bubble_mode_e MODE = CLR_ON_BUBBLE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         stall_ex,
  input  logic         stall_mem,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_q, q_d;

  // Feedback bundles invert the rule: latched while execute is stalled, dropped once it advances.
  always_comb begin
    q_d = q_q;
    if (flush)                      q_d = '0;
    else if (stall_ex && !stall_mem) q_d = (MODE == CAP_ON_BUBBLE) ? d : '0;
    else if (!stall_ex)             q_d = (MODE == CAP_ON_BUBBLE) ? '0 : d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/flush handling and multiply-accumulate feedback.
// Define EX_MEM_MADD_EN to build the hilo_o/cnt_o feedback registers; otherwise they read 0.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic                    flush,
  input  logic [RegAddrBus-1:0]   ex_wd,
  input  logic                    ex_wreg,
  input  logic [RegBus-1:0]       ex_wdata,
  input  logic                    ex_whilo,
  input  logic [RegBus-1:0]       ex_hi,
  input  logic [RegBus-1:0]       ex_lo,
  input  logic [DoubleRegBus-1:0] hilo_i,
  input  logic [1:0]              cnt_i,
  output logic [RegAddrBus-1:0]   mem_wd,
  output logic                    mem_wreg,
  output logic [RegBus-1:0]       mem_wdata,
  output logic                    mem_whilo,
  output logic [RegBus-1:0]       mem_hi,
  output logic [RegBus-1:0]       mem_lo,
  output logic [DoubleRegBus-1:0] hilo_o,
  output logic [1:0]              cnt_o
);
  mem_bundle_t ex_b, mem_b;
  logic        unused_stall;

  assign unused_stall = ^{stall[STALL_PC], stall[STALL_IF], stall[STALL_ID], stall[STALL_WB]};

  assign ex_b = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata,
                  whilo: ex_whilo, hi: ex_hi, lo: ex_lo};

  pipe_reg #(.W($bits(mem_bundle_t)), .MODE(CLR_ON_BUBBLE)) u_mem_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_ex  (stall[STALL_EX]),
    .stall_mem (stall[STALL_MEM]),
    .d         (ex_b),
    .q         (mem_b)
  );

  assign mem_wd    = mem_b.wd;
  assign mem_wreg  = mem_b.wreg;
  assign mem_wdata = mem_b.wdata;
  assign mem_whilo = mem_b.whilo;
  assign mem_hi    = mem_b.hi;
  assign mem_lo    = mem_b.lo;

`ifdef EX_MEM_MADD_EN
  pipe_reg #(.W(DoubleRegBus + 2), .MODE(CAP_ON_BUBBLE)) u_madd_reg (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .stall_ex  (stall[STALL_EX]),
    .stall_mem (stall[STALL_MEM]),
    .d         ({hilo_i, cnt_i}),
    .q         ({hilo_o, cnt_o})
  );
`else
  logic unused_madd;
  assign unused_madd = ^{hilo_i, cnt_i};
  assign hilo_o      = '0;
  assign cnt_o       = '0;
`endif
endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, pass, hold, bubble/MAC feedback, flush priority, async reset.
module tb_ex_mem;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi, mem_lo;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int total = 0;
  int bad   = 0;

`ifdef EX_MEM_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wd"},    64'(mem_wd),    64'd0);
    chk({tag, ".wreg"},  64'(mem_wreg),  64'd0);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, ".whilo"}, 64'(mem_whilo), 64'd0);
    chk({tag, ".hi"},    64'(mem_hi),    64'd0);
    chk({tag, ".lo"},    64'(mem_lo),    64'd0);
    chk({tag, ".hilo"},  hilo_o,         64'd0);
    chk({tag, ".cnt"},   64'(cnt_o),     64'd0);
  endtask

  initial begin
    rst = 1'b0; stall = 6'b0; flush = 1'b0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678; ex_whilo = 1'b1;
    ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222;
    hilo_i = 64'h0; cnt_i = 2'd0;

    // Reset held with live inputs and running clock
    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();
    chk("rst_release.wdata", 64'(mem_wdata), 64'h1234_5678);
    chk("rst_release.hi",    64'(mem_hi),    64'h1111_1111);

    // Pass
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1'b0;
    ex_hi = 32'hA; ex_lo = 32'hB;
    step();
    chk("pass.wd",    64'(mem_wd),    64'd5);
    chk("pass.wreg",  64'(mem_wreg),  64'd1);
    chk("pass.wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    chk("pass.whilo", 64'(mem_whilo), 64'd0);
    chk("pass.lo",    64'(mem_lo),    64'hB);

    // Hold for 3 cycles while inputs change
    stall = 6'b011111; ex_wd = 5'd7; ex_wdata = 32'hFFFF_FFFF; ex_whilo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    end
    chk("hold.wd",    64'(mem_wd),    64'd5);
    chk("hold.whilo", 64'(mem_whilo), 64'd0);

    // Bubble latches MAC state, clears forward bundle
    stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    step();
    chk("bubble.wreg",  64'(mem_wreg),  64'd0);
    chk("bubble.wdata", 64'(mem_wdata), 64'd0);
    chk("bubble.wd",    64'(mem_wd),    64'd0);
    chk("bubble.hilo",  hilo_o,         MADD ? 64'h0000_0001_0000_0002 : 64'd0);
    chk("bubble.cnt",   64'(cnt_o),     MADD ? 64'd1 : 64'd0);

    // Hold keeps MAC state even though inputs move
    stall = 6'b011111; hilo_i = 64'hFFFF; cnt_i = 2'd3;
    step();
    chk("madd_hold.hilo", hilo_o,     MADD ? 64'h0000_0001_0000_0002 : 64'd0);
    chk("madd_hold.cnt",  64'(cnt_o), MADD ? 64'd1 : 64'd0);

    // Pass completes MAC: result forwarded, feedback cleared
    stall = 6'b0; ex_wdata = 32'h0000_0055; ex_wd = 5'd9;
    step();
    chk("madd_pass.wdata", 64'(mem_wdata), 64'h55);
    chk("madd_pass.wd",    64'(mem_wd),    64'd9);
    chk("madd_pass.cnt",   64'(cnt_o),     64'd0);
    chk("madd_pass.hilo",  hilo_o,         64'd0);

    // Reload MAC state, then flush with every stall bit set
    stall = 6'b001111; hilo_i = 64'hCAFE; cnt_i = 2'd2;
    step();
    chk("pre_flush.cnt", 64'(cnt_o), MADD ? 64'd2 : 64'd0);
    stall = 6'b0; ex_wdata = 32'h7777_0000; ex_hi = 32'h5; ex_whilo = 1'b1;
    step();
    chk("pre_flush.wdata", 64'(mem_wdata), 64'h7777_0000);
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h99;
    step();
    stall = 6'b111111; flush = 1'b1; ex_wdata = 32'h1; cnt_i = 2'd3;
    step();
    chk_all_zero("flush");
    flush = 1'b0;

    // Async reset during a hold clears outputs before the next edge
    stall = 6'b0; ex_wdata = 32'hABCD_0123; ex_wreg = 1'b1;
    step();
    chk("pre_async.wdata", 64'(mem_wdata), 64'hABCD_0123);
    stall = 6'b011111;
    step();
    #2 rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 rst = 1'b1;
    step();
    chk("post_async.hold", 64'(mem_wdata), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
